// File: rtl/pulse_burst_scheduler.sv
// Burst scheduler for the LFM accumulator and noise generator sharing the
// output register: launches pulses, times the repetition period, flags errors.
module pulse_burst_scheduler #(
    parameter int unsigned CLK_PER_US = 100,
    parameter logic [15:0] ACK_TMO    = 16'd1023
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CFG_VALID,
    output logic        CFG_READY,
    input  logic        CFG_SRC,
    input  logic [9:0]  CFG_T_IMPULSE,
    input  logic [15:0] CFG_T_PERIOD,
    input  logic [7:0]  CFG_NUM_PULSES,
    input  logic        ABORT,
    output logic        START_GEN_LFM,
    output logic        START_GEN_NOISE,
    output logic [9:0]  T_IMPULSE_OUT,
    input  logic        CALC_START_LFM,
    input  logic        CALC_START_NOISE,
    input  logic        CALC_STOP_LFM,
    input  logic        CALC_STOP_NOISE,
    output logic        OUT_SEL,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR_OVERRUN,
    output logic        ERR_ACK,
    output logic [7:0]  PULSE_IDX
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_STOP,
        GAP,
        FINISH
    } state_t;

    state_t      state;
    logic [15:0] per_q;
    logic [7:0]  num_q;
    logic [31:0] cnt;
    logic [16:0] ack_tmr;

    logic        calc_start;
    logic        calc_stop;
    logic [15:0] per_sel;
    logic [31:0] per_prod;
    logic [31:0] per_load;

    // OUT_SEL doubles as the latched source for the whole burst
    assign calc_start = OUT_SEL ? CALC_START_NOISE : CALC_START_LFM;
    assign calc_stop  = OUT_SEL ? CALC_STOP_NOISE : CALC_STOP_LFM;

    // The first launch loads straight from the command being accepted
    assign per_sel  = (state == IDLE) ? CFG_T_PERIOD : per_q;
    assign per_prod = {16'd0, per_sel} * 32'(CLK_PER_US);
    assign per_load = (per_prod == 32'd0) ? 32'd0 : per_prod - 32'd1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= IDLE;
            CFG_READY       <= 1'b1;
            START_GEN_LFM   <= 1'b0;
            START_GEN_NOISE <= 1'b0;
            T_IMPULSE_OUT   <= '0;
            OUT_SEL         <= 1'b0;
            BUSY            <= 1'b0;
            DONE            <= 1'b0;
            ERR_OVERRUN     <= 1'b0;
            ERR_ACK         <= 1'b0;
            PULSE_IDX       <= '0;
            per_q           <= '0;
            num_q           <= '0;
            cnt             <= '0;
            ack_tmr         <= '0;
        end else begin
            DONE <= 1'b0;
            if (cnt != 32'd0) begin
                cnt <= cnt - 32'd1;
            end
            if (ABORT && state != IDLE) begin
                state           <= IDLE;
                START_GEN_LFM   <= 1'b0;
                START_GEN_NOISE <= 1'b0;
                BUSY            <= 1'b0;
                CFG_READY       <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (CFG_VALID && CFG_READY) begin
                            OUT_SEL       <= CFG_SRC;
                            T_IMPULSE_OUT <= CFG_T_IMPULSE;
                            per_q         <= CFG_T_PERIOD;
                            num_q         <= CFG_NUM_PULSES;
                            ERR_OVERRUN   <= 1'b0;
                            ERR_ACK       <= 1'b0;
                            PULSE_IDX     <= '0;
                            BUSY          <= 1'b1;
                            CFG_READY     <= 1'b0;
                            if (CFG_NUM_PULSES == 8'd0) begin
                                state <= FINISH;
                            end else begin
                                state           <= LAUNCH;
                                START_GEN_NOISE <= CFG_SRC;
                                START_GEN_LFM   <= !CFG_SRC;
                                cnt             <= per_load;
                                ack_tmr         <= 17'd1;
                            end
                        end
                    end
                    LAUNCH: begin
                        if (calc_start) begin
                            START_GEN_LFM   <= 1'b0;
                            START_GEN_NOISE <= 1'b0;
                            state           <= WAIT_STOP;
                        end else if (ack_tmr > {1'b0, ACK_TMO}) begin
                            ERR_ACK         <= 1'b1;
                            START_GEN_LFM   <= 1'b0;
                            START_GEN_NOISE <= 1'b0;
                            state           <= FINISH;
                        end else begin
                            ack_tmr <= ack_tmr + 17'd1;
                        end
                    end
                    WAIT_STOP: begin
                        if (calc_stop) begin
                            PULSE_IDX <= PULSE_IDX + 8'd1;
                            state     <= GAP;
                        end else if (cnt == 32'd0) begin
                            ERR_OVERRUN <= 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt == 32'd0) begin
                            if (PULSE_IDX >= num_q) begin
                                state <= FINISH;
                            end else begin
                                state           <= LAUNCH;
                                START_GEN_NOISE <= OUT_SEL;
                                START_GEN_LFM   <= !OUT_SEL;
                                cnt             <= per_load;
                                ack_tmr         <= 17'd1;
                            end
                        end
                    end
                    FINISH: begin
                        DONE      <= !ERR_ACK;
                        BUSY      <= 1'b0;
                        CFG_READY <= 1'b1;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Scoreboard bench for pulse_burst_scheduler: launch, pulse-step and DONE
// events are queued at command time and matched by an independent monitor.
module tb_pulse_burst_scheduler;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CFG_VALID = 1'b0;
    logic        CFG_READY;
    logic        CFG_SRC = 1'b0;
    logic [9:0]  CFG_T_IMPULSE = '0;
    logic [15:0] CFG_T_PERIOD = '0;
    logic [7:0]  CFG_NUM_PULSES = '0;
    logic        ABORT = 1'b0;
    logic        START_GEN_LFM;
    logic        START_GEN_NOISE;
    logic [9:0]  T_IMPULSE_OUT;
    logic        CALC_START_LFM = 1'b0;
    logic        CALC_START_NOISE = 1'b0;
    logic        CALC_STOP_LFM = 1'b0;
    logic        CALC_STOP_NOISE = 1'b0;
    logic        OUT_SEL;
    logic        BUSY;
    logic        DONE;
    logic        ERR_OVERRUN;
    logic        ERR_ACK;
    logic [7:0]  PULSE_IDX;

    pulse_burst_scheduler #(
        .CLK_PER_US(4),
        .ACK_TMO   (16'd5)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .CFG_VALID       (CFG_VALID),
        .CFG_READY       (CFG_READY),
        .CFG_SRC         (CFG_SRC),
        .CFG_T_IMPULSE   (CFG_T_IMPULSE),
        .CFG_T_PERIOD    (CFG_T_PERIOD),
        .CFG_NUM_PULSES  (CFG_NUM_PULSES),
        .ABORT           (ABORT),
        .START_GEN_LFM   (START_GEN_LFM),
        .START_GEN_NOISE (START_GEN_NOISE),
        .T_IMPULSE_OUT   (T_IMPULSE_OUT),
        .CALC_START_LFM  (CALC_START_LFM),
        .CALC_START_NOISE(CALC_START_NOISE),
        .CALC_STOP_LFM   (CALC_STOP_LFM),
        .CALC_STOP_NOISE (CALC_STOP_NOISE),
        .OUT_SEL         (OUT_SEL),
        .BUSY            (BUSY),
        .DONE            (DONE),
        .ERR_OVERRUN     (ERR_OVERRUN),
        .ERR_ACK         (ERR_ACK),
        .PULSE_IDX       (PULSE_IDX)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t sb[$];
    int  n_chk = 0;
    int  n_fail = 0;
    bit  gen_src = 1'b0;
    bit  ack_en = 1'b1;

    localparam int EV_LAUNCH = 0;
    localparam int EV_STEP   = 1;
    localparam int EV_DONE   = 2;
    localparam int RST_OUTS  = 32'h200_0000;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int outs();
        return int'({CFG_READY, START_GEN_LFM, START_GEN_NOISE, OUT_SEL,
                     BUSY, DONE, ERR_OVERRUN, ERR_ACK,
                     T_IMPULSE_OUT, PULSE_IDX});
    endfunction

    function automatic int lval(input bit src, input int timp);
        return src ? ((1 << 11) | (1 << 10) | timp) : ((1 << 12) | timp);
    endfunction

    task automatic push(input int k, input int c, input int v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic got_ev(input int k, input int v);
        ev_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: kind %0d val %0h at cycle %0d",
                     k, v, cyc);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", k, e.kind);
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_value", v, e.val);
        end
    endtask

    // Monitor: one event per launch edge, pulse completion and DONE
    bit           p_lfm = 1'b0;
    bit           p_noise = 1'b0;
    logic [7:0]   p_idx = '0;
    always @(negedge CLK) begin
        if ((START_GEN_LFM && !p_lfm) || (START_GEN_NOISE && !p_noise))
            got_ev(EV_LAUNCH, int'({START_GEN_LFM, START_GEN_NOISE,
                                    OUT_SEL, T_IMPULSE_OUT}));
        if (PULSE_IDX != p_idx && PULSE_IDX != 8'd0)
            got_ev(EV_STEP, int'(PULSE_IDX));
        if (DONE)
            got_ev(EV_DONE, 1);
        p_lfm   <= START_GEN_LFM;
        p_noise <= START_GEN_NOISE;
        p_idx   <= PULSE_IDX;
    end

    // Generator model: ack 2 cycles after start rises, stop 8 after ack
    initial begin
        bit s;
        bit sp;
        int rise;
        bit st;
        bit so;
        sp = 1'b0;
        rise = -1000;
        forever begin
            @(negedge CLK);
            s = gen_src ? START_GEN_NOISE : START_GEN_LFM;
            if (s && !sp) rise = cyc;
            sp = s;
            st = ack_en && (cyc == rise + 2);
            so = ack_en && (cyc == rise + 10);
            CALC_START_LFM   = st && !gen_src;
            CALC_START_NOISE = st && gen_src;
            CALC_STOP_LFM    = so && !gen_src;
            CALC_STOP_NOISE  = so && gen_src;
        end
    end

    task automatic at(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    task automatic issue(input bit src, input int timp, input int per,
                         input int num, input bit abt, output int acc);
        CFG_SRC        = src;
        CFG_T_IMPULSE  = 10'(timp);
        CFG_T_PERIOD   = 16'(per);
        CFG_NUM_PULSES = 8'(num);
        CFG_VALID      = 1'b1;
        ABORT          = abt;
        gen_src        = src;
        chk("ready_before_accept", int'(CFG_READY), 1);
        acc = cyc;
    endtask

    task automatic release_cmd();
        @(negedge CLK);
        CFG_VALID = 1'b0;
        ABORT     = 1'b0;
    endtask

    task automatic drained(input string name);
        chk(name, sb.size(), 0);
    endtask

    int a;
    int l0;

    initial begin
        repeat (3) @(negedge CLK);
        chk("reset_outputs", outs(), RST_OUTS);
        RESET = 1'b0;
        @(negedge CLK);

        // Noise burst of 3, period 10 us = 40 cycles
        issue(1'b1, 2, 10, 3, 1'b0, a);
        l0 = a + 1;
        push(EV_LAUNCH, l0, lval(1'b1, 2));
        push(EV_STEP, l0 + 11, 1);
        push(EV_LAUNCH, l0 + 40, lval(1'b1, 2));
        push(EV_STEP, l0 + 51, 2);
        push(EV_LAUNCH, l0 + 80, lval(1'b1, 2));
        push(EV_STEP, l0 + 91, 3);
        push(EV_DONE, l0 + 121, 1);
        release_cmd();
        chk("busy_after_accept", int'(BUSY), 1);
        chk("ready_low_in_burst", int'(CFG_READY), 0);
        at(l0 + 60);
        chk("timp_stable", int'(T_IMPULSE_OUT), 2);
        chk("out_sel_stable", int'(OUT_SEL), 1);
        chk("lfm_idle", int'(START_GEN_LFM), 0);
        at(l0 + 121);
        chk("busy_at_done", int'(BUSY), 0);
        chk("no_overrun", int'(ERR_OVERRUN), 0);
        at(l0 + 123);
        drained("drain_burst3");

        // Zero-pulse command
        issue(1'b0, 7, 10, 0, 1'b0, a);
        push(EV_DONE, a + 2, 1);
        release_cmd();
        chk("busy_num0", int'(BUSY), 1);
        at(a + 2);
        chk("busy_num0_end", int'(BUSY), 0);
        chk("ready_num0_end", int'(CFG_READY), 1);
        at(a + 4);
        drained("drain_num0");

        // Period of 4 cycles shorter than the 10-cycle pulse
        issue(1'b0, 5, 1, 2, 1'b0, a);
        l0 = a + 1;
        push(EV_LAUNCH, l0, lval(1'b0, 5));
        push(EV_STEP, l0 + 11, 1);
        push(EV_LAUNCH, l0 + 12, lval(1'b0, 5));
        push(EV_STEP, l0 + 23, 2);
        push(EV_DONE, l0 + 25, 1);
        release_cmd();
        at(l0 + 3);
        chk("overrun_before", int'(ERR_OVERRUN), 0);
        at(l0 + 4);
        chk("overrun_set", int'(ERR_OVERRUN), 1);
        at(l0 + 27);
        chk("overrun_sticky", int'(ERR_OVERRUN), 1);
        chk("overrun_no_ackerr", int'(ERR_ACK), 0);
        drained("drain_overrun");

        // Generator never acknowledges
        ack_en = 1'b0;
        issue(1'b1, 3, 10, 2, 1'b0, a);
        l0 = a + 1;
        push(EV_LAUNCH, l0, lval(1'b1, 3));
        release_cmd();
        chk("overrun_cleared", int'(ERR_OVERRUN), 0);
        at(l0 + 5);
        chk("ackerr_before", int'(ERR_ACK), 0);
        chk("start_held", int'(START_GEN_NOISE), 1);
        at(l0 + 6);
        chk("ackerr_set", int'(ERR_ACK), 1);
        chk("start_dropped", int'(START_GEN_NOISE), 0);
        at(l0 + 7);
        chk("ackerr_ready", int'(CFG_READY), 1);
        chk("ackerr_busy", int'(BUSY), 0);
        at(l0 + 12);
        drained("drain_ackerr");
        ack_en = 1'b1;

        // Abort during the second pulse
        issue(1'b1, 4, 10, 3, 1'b0, a);
        l0 = a + 1;
        push(EV_LAUNCH, l0, lval(1'b1, 4));
        push(EV_STEP, l0 + 11, 1);
        push(EV_LAUNCH, l0 + 40, lval(1'b1, 4));
        release_cmd();
        chk("ackerr_cleared", int'(ERR_ACK), 0);
        at(l0 + 45);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("abort_start", int'({START_GEN_LFM, START_GEN_NOISE}), 0);
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_ready", int'(CFG_READY), 1);
        chk("abort_idx", int'(PULSE_IDX), 1);
        at(l0 + 100);
        chk("abort_idx_hold", int'(PULSE_IDX), 1);
        drained("drain_abort");

        // Reset in GAP, then an LFM command issued together with ABORT
        issue(1'b1, 9, 10, 3, 1'b0, a);
        l0 = a + 1;
        push(EV_LAUNCH, l0, lval(1'b1, 9));
        push(EV_STEP, l0 + 11, 1);
        release_cmd();
        at(l0 + 20);
        RESET = 1'b1;
        @(negedge CLK);
        chk("reset_in_gap", outs(), RST_OUTS);
        RESET = 1'b0;
        @(negedge CLK);
        issue(1'b0, 6, 10, 1, 1'b1, a);
        push(EV_LAUNCH, a + 1, lval(1'b0, 6));
        push(EV_STEP, a + 12, 1);
        push(EV_DONE, a + 42, 1);
        release_cmd();
        chk("idle_abort_ignored", int'(BUSY), 1);
        at(a + 44);
        drained("drain_after_reset");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pulse_burst_scheduler.md
Name: pulse_burst_scheduler

Overview:
Sequences the noise generator and the LFM phase accumulator that share the output register, and accepts one burst command at a time. A command gives the source, pulse width, repetition period and pulse count. The block launches each pulse on the selected generator, tracks its start/stop flags, and times the repetition period in clock cycles. It reports busy, done and overrun status to the host-side control logic.

Parameters:
CLK_PER_US, 100, controller clock cycles per microsecond; period counter scale.
ACK_TMO, 16'd1023, max cycles to wait for the generator's start-calc acknowledge before flagging a launch error.

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
CFG_VALID  in  1  command valid
CFG_READY  out  1  command accepted when VALID&&READY
CFG_SRC  in  1  0 = LFM, 1 = noise
CFG_T_IMPULSE  in  10  pulse width, us
CFG_T_PERIOD  in  16  repetition period, us
CFG_NUM_PULSES  in  8  pulses in burst
ABORT  in  1  terminate burst
START_GEN_LFM  out  1  start request to LFM accumulator
START_GEN_NOISE  out  1  start request to noise generator
T_IMPULSE_OUT  out  10  latched pulse width driven to both generators
CALC_START_LFM / CALC_START_NOISE  in  1  generator start-calc flags
CALC_STOP_LFM / CALC_STOP_NOISE  in  1  generator stop-calc flags
OUT_SEL  out  1  output-register mux select (= latched SRC)
BUSY  out  1  burst in progress
DONE  out  1  one-cycle pulse at normal burst completion
ERR_OVERRUN  out  1  sticky: period expired before pulse stopped
ERR_ACK  out  1  sticky: acknowledge timeout
PULSE_IDX  out  8  pulses completed in current burst

Behaviour:
- Reset: state IDLE.
  - CFG_READY=1; START_GEN_* = 0; T_IMPULSE_OUT=0; OUT_SEL=0; BUSY=0; DONE=0; ERR_*=0; PULSE_IDX=0; period counter 0.
  - Reset mid-burst drops START_GEN_* the next edge.
- All generator flags are in the CLK domain; no synchronisers.
- States: IDLE, LAUNCH, WAIT_STOP, GAP, FINISH.
- IDLE:
  - CFG_READY=1.
  - On VALID&&READY: latch SRC, T_IMPULSE, T_PERIOD and NUM_PULSES; clear ERR_*; PULSE_IDX=0.
  - NUM_PULSES==0: go to FINISH (DONE the following cycle, no launch).
  - Otherwise go to LAUNCH; BUSY=1 and CFG_READY=0 from the next cycle.
- LAUNCH:
  - Selected START_GEN held high. The other START_GEN stays 0 always.
  - On the first cycle, load period counter = T_PERIOD*CLK_PER_US-1 (32-bit product). It decrements every cycle, saturating at 0.
  - On selected CALC_START==1: drop START_GEN the next edge and go to WAIT_STOP.
  - ACK timer > ACK_TMO: set ERR_ACK, drop START_GEN, go to FINISH (no DONE).
- WAIT_STOP:
  - On selected CALC_STOP==1: PULSE_IDX+1, go to GAP.
  - If the counter reaches 0 before the stop: set ERR_OVERRUN and keep waiting. The next launch follows the stop immediately (no extra gap).
- GAP:
  - Counter==0 and PULSE_IDX==NUM_PULSES: go to FINISH.
  - Counter==0 and PULSE_IDX<NUM_PULSES: go to LAUNCH (counter reloads there).
  - Stop and counter-zero in the same cycle are handled as two steps: WAIT_STOP→GAP, then GAP acts next cycle.
- FINISH:
  - DONE=1 for exactly one cycle, only if no ERR_ACK.
  - BUSY=0, CFG_READY=1 the next cycle; return to IDLE.
- ABORT (non-IDLE): next edge START_GEN_*=0, go to IDLE, BUSY=0, no DONE. ERR_* and PULSE_IDX hold.
  - ABORT with RESET: RESET wins.
  - ABORT in IDLE is ignored, even with CFG_VALID, which is then accepted.
- The VALID&&READY command is accepted only in IDLE. VALID in other states is held off by READY=0.
- T_IMPULSE_OUT and OUT_SEL are stable for the whole burst.

Test Plan:
- CLK_PER_US=4; SRC=1, T_IMPULSE=2, T_PERIOD=10, NUM=3; generator model acks after 2 cycles and stops 8 cycles after ack.
  - START_GEN_NOISE rises 1 cycle after accept.
  - Launches are spaced 40 cycles apart.
  - PULSE_IDX steps 1,2,3; DONE pulses once; START_GEN_LFM stays 0.
- NUM_PULSES=0 → no START_GEN; DONE 2 cycles after accept; BUSY high 1 cycle.
- T_PERIOD=1 (4 cycles) with stop at 8 cycles → ERR_OVERRUN=1; each next launch is 1 cycle after stop; DONE still asserted.
- Generator never acks, ACK_TMO=5 → ERR_ACK at cycle 6 of LAUNCH; START_GEN low; no DONE; READY back high.
- ABORT in WAIT_STOP of pulse 2 → START_GEN_* 0, BUSY 0 next cycle; PULSE_IDX=1; DONE never asserted.
- RESET asserted during GAP → all outputs at reset values next cycle. A new SRC=0 command afterwards launches START_GEN_LFM with OUT_SEL=0.
